// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: baud encodings, FSM states and divisor helper shared by the UART TX core (PARITY state present only with UART_TX_PARITY_EN)
package uart_tx_pkg;

    localparam logic [1:0] BAUD_9600   = 2'd0;
    localparam logic [1:0] BAUD_38400  = 2'd1;
    localparam logic [1:0] BAUD_115200 = 2'd2;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // Reserved encoding 3 falls back to 9600 baud.
    function automatic logic [15:0] baud_div(input int unsigned clk_freq, input logic [1:0] sel);
        return 16'(clk_freq / (sel == BAUD_115200 ? 115200 : sel == BAUD_38400 ? 38400 : 9600));
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with wrap-bit pointers; a push into a full FIFO succeeds only alongside a pop
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr;
    logic [AW:0] rd;
    logic do_push;
    logic do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign empty   = wr == rd;
    assign rdata   = mem[rd[AW-1:0]];

    // Pointer update; the extra top bit tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            wr <= do_push ? wr + ONE : wr;
            rd <= do_pop ? rd + ONE : rd;
        end
    end

    // Storage needs no reset; contents are only read when non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter with TX FIFO, prescaled baud timing and optional even parity (UART_TX_PARITY_EN)
module uart_tx_core
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [1:0] baud_sel,
    input  logic       two_stop,
    input  logic       lpm_en,
    input  logic [7:0] lpm_div,
    input  logic [7:0] wdata,
    input  logic       wvalid,
    output logic       txf,
    output logic       busy,
    output logic       ovf,
    output logic       tx_int,
    output logic       txd
);

    localparam logic [15:0] DIV0 = baud_div(CLK_FREQ, BAUD_9600);
    localparam logic [15:0] DIV1 = baud_div(CLK_FREQ, BAUD_38400);
    localparam logic [15:0] DIV2 = baud_div(CLK_FREQ, BAUD_115200);

    state_t      state;
    logic [7:0]  shreg;
    logic [2:0]  bidx;
    logic [7:0]  pre;
    logic [15:0] cnt;
    logic [15:0] div_q;
    logic [7:0]  lpm_q;
    logic        two_q;
    logic        stop2;
    logic [7:0]  rdata;
    logic        empty;
    logic        pop;
    logic        tick;
`ifdef UART_TX_PARITY_EN
    logic        par;
`endif

    assign pop  = (state == IDLE) & tx_en & ~empty;
    assign tick = (pre == lpm_q) && (cnt == div_q - 16'd1);
    assign busy = (state != IDLE) | ~empty;

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wvalid),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (txf),
        .empty (empty)
    );

    // A push is dropped only when full and nothing leaves the FIFO that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf <= 1'b0;
        else     ovf <= wvalid & txf & ~pop;
    end

    // Frame FSM with prescaler and bit counter; txd and tx_int are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            txd    <= 1'b1;
            tx_int <= 1'b0;
            shreg  <= '0;
            bidx   <= '0;
            pre    <= '0;
            cnt    <= '0;
            div_q  <= DIV0;
            lpm_q  <= '0;
            two_q  <= 1'b0;
            stop2  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            tx_int <= 1'b0;
            pre    <= (pre == lpm_q) ? 8'd0 : pre + 8'd1;
            cnt    <= (pre != lpm_q) ? cnt : (cnt == div_q - 16'd1) ? 16'd0 : cnt + 16'd1;
            case (state)
                IDLE: begin
                    pre <= '0;
                    cnt <= '0;
                    if (pop) begin
                        shreg <= rdata;
                        div_q <= baud_sel == BAUD_115200 ? DIV2 : baud_sel == BAUD_38400 ? DIV1 : DIV0;
                        lpm_q <= lpm_en ? lpm_div : 8'd0;
                        two_q <= two_stop;
`ifdef UART_TX_PARITY_EN
                        par   <= ^rdata;
`endif
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        txd   <= shreg[0];
                        bidx  <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= shreg >> 1;
                        txd   <= shreg[1];
                        bidx  <= bidx + 3'd1;
                        if (bidx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= par;
`else
                            state <= STOP;
                            txd   <= 1'b1;
                            stop2 <= 1'b0;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        txd   <= 1'b1;
                        stop2 <= 1'b0;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (two_q && !stop2) begin
                            stop2 <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            tx_int <= empty;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed self-checking bench for uart_tx_core at CLK_FREQ=1152000 (divisors 120/30/10)
module tb_uart_tx_core;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       tx_en;
    logic [1:0] baud_sel;
    logic       two_stop;
    logic       lpm_en;
    logic [7:0] lpm_div;
    logic [7:0] wdata;
    logic       wvalid;
    logic       txf;
    logic       busy;
    logic       ovf;
    logic       tx_int;
    logic       txd;

    int total = 0;
    int fails = 0;

    uart_tx_core #(.CLK_FREQ(1152000), .FIFO_DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_en    (tx_en),
        .baud_sel (baud_sel),
        .two_stop (two_stop),
        .lpm_en   (lpm_en),
        .lpm_div  (lpm_div),
        .wdata    (wdata),
        .wvalid   (wvalid),
        .txf      (txf),
        .busy     (busy),
        .ovf      (ovf),
        .tx_int   (tx_int),
        .txd      (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input logic [7:0] b, input int idx, input bit par);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && par) return ^b;
        return 1'b1;
    endfunction

    // Called on the first start-bit cycle; returns on the idle cycle after the frame.
    task automatic frame(input string tag, input logic [7:0] b, input int p, input bit two, input logic exp_int);
        int nb = 10 + int'(PAR) + int'(two);
        for (int i = 0; i < nb * p; i++) begin
            chk(tag, txd, bit_at(b, i / p, PAR));
            step();
        end
        chk({tag, "_int"}, tx_int, exp_int);
        chk({tag, "_idle"}, txd, 1'b1);
    endtask

    initial begin
        rst = 1'b1; tx_en = 1'b0; baud_sel = 2'd2; two_stop = 1'b0;
        lpm_en = 1'b0; lpm_div = 8'd0; wdata = 8'd0; wvalid = 1'b0;
        step(); step();
        chk("rst_txd", txd, 1'b1);
        chk("rst_txf", txf, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_int", tx_int, 1'b0);
        rst = 1'b0;
        step();

        // 1: single 0xA5 frame at 115200, start at cycle 2, tx_int at cycle 102
        tx_en = 1'b1; wdata = 8'hA5; wvalid = 1'b1;
        chk("t1_c0_txd", txd, 1'b1);
        step();
        wvalid = 1'b0;
        chk("t1_c1_txd", txd, 1'b1);
        chk("t1_c1_busy", busy, 1'b1);
        step();
        frame("t1_a5", 8'hA5, 10, 1'b0, 1'b1);
        chk("t1_busy_end", busy, 1'b0);
        step();
        chk("t1_int_once", tx_int, 1'b0);

        // 2: fill with tx_en=0, overflow on the 9th byte, then drain 8 frames
        tx_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wdata = 8'((i + 1) * 8'h11); wvalid = 1'b1;
            chk("t2_txf_fill", txf, i == 8);
            chk("t2_ovf_quiet", ovf, 1'b0);
            step();
        end
        wvalid = 1'b0;
        chk("t2_ovf_pulse", ovf, 1'b1);
        chk("t2_txf_full", txf, 1'b1);
        chk("t2_txd_held", txd, 1'b1);
        step();
        chk("t2_ovf_end", ovf, 1'b0);
        chk("t2_busy_held", busy, 1'b1);
        tx_en = 1'b1;
        step();
        chk("t2_txf_pop", txf, 1'b0);
        for (int i = 0; i < 8; i++) begin
            frame("t2_frame", 8'((i + 1) * 8'h11), 10, 1'b0, i == 7);
            step();
        end
        chk("t2_busy_end", busy, 1'b0);

        // 3: lpm prescale x4 gives 40-cycle bits; lpm_div change applies next frame
        lpm_en = 1'b1; lpm_div = 8'd3; wdata = 8'h00; wvalid = 1'b1;
        step();
        wdata = 8'h81;
        step();
        wvalid = 1'b0; lpm_div = 8'd0;
        frame("t3_lpm40", 8'h00, 40, 1'b0, 1'b0);
        step();
        frame("t3_lpm10", 8'h81, 10, 1'b0, 1'b1);
        step();
        lpm_en = 1'b0;

        // 4: reserved baud -> 9600 (120 cycles), two stop bits
        two_stop = 1'b1; baud_sel = 2'd3; wdata = 8'hFF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        step();
        frame("t4_two_stop", 8'hFF, 120, 1'b1, 1'b1);
        step();
        two_stop = 1'b0; baud_sel = 2'd2;

        // 5: async reset during data bit 3 with a full FIFO, then a clean frame
        for (int i = 0; i < 9; i++) begin
            wdata = (i == 0) ? 8'hF0 : 8'h5A; wvalid = 1'b1;
            step();
        end
        wvalid = 1'b0;
        chk("t5_txf_full", txf, 1'b1);
        for (int i = 9; i < 45; i++) step();
        chk("t5_bit3", txd, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_rst_txd", txd, 1'b1);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_txf", txf, 1'b0);
        step();
        rst = 1'b0; wdata = 8'h3C; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("t5_c1_txd", txd, 1'b1);
        step();
        frame("t5_3c", 8'h3C, 10, 1'b0, 1'b1);
        step();

`ifdef UART_TX_PARITY_EN
        // 6: even parity, 0xA5 -> 0, 0x07 -> 1, 110-cycle frames
        chk("t6_par_a5", bit_at(8'hA5, 9, PAR), 1'b0);
        chk("t6_par_07", bit_at(8'h07, 9, PAR), 1'b1);
        wdata = 8'hA5; wvalid = 1'b1;
        step();
        wdata = 8'h07;
        step();
        wvalid = 1'b0;
        frame("t6_a5", 8'hA5, 10, 1'b0, 1'b0);
        step();
        frame("t6_07", 8'h07, 10, 1'b0, 1'b1);
        step();
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
